// File: rtl/if_fetch.sv
// Instruction fetch unit: issues one instruction-bus read at a time from the
// current PC, presents the returned word as a registered instruction with its
// address, and handles downstream stall, jump flush and bus timeout.
module if_fetch #(
   parameter logic [31:0] NOP_INST = 32'h00000013,
   parameter int          TIMEOUT  = 255,
   parameter int          TO_W     = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_i,
   input  logic        flush_i,
   input  logic        stall_i,
   output logic        ibus_req_o,
   output logic [31:0] ibus_addr_o,
   input  logic        ibus_gnt_i,
   input  logic        ibus_rvalid_i,
   input  logic [31:0] ibus_rdata_i,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o,
   output logic        inst_valid_o,
   output logic        hold_pc_o,
   output logic        fetch_err_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DROP = 2'd3
   } state_t;

   // Saturation value and the last count before an abort fires.
   localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic [TO_W-1:0]   cnt_q, cnt_d;
   logic              req_q, req_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       inst_q, inst_d;
   logic [31:0]       inst_addr_q, inst_addr_d;
   logic              valid_q, valid_d;
   logic              err_q, err_d;

   logic              blocked;
   logic              accept;
   logic              to_hit;
   logic [31:0]       pc_al;
   logic [TO_W-1:0]   cnt_inc;
   logic              load;
   logic [31:0]       load_data;

   // A held, valid instruction under stall freezes the output stage.
   assign blocked = stall_i && valid_q;
   assign accept  = (state_q == S_WAIT) && ibus_rvalid_i && !flush_i && !blocked;
   assign to_hit  = !ibus_rvalid_i && (cnt_q >= TO_LAST);
   assign pc_al   = pc_i & 32'hFFFF_FFFC;
   assign cnt_inc = (cnt_q == TO_MAX) ? cnt_q : cnt_q + 1'b1;

   // Next-state, address latch, timeout counter and output-stage decisions.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      inst_d      = inst_q;
      inst_addr_d = inst_addr_q;
      valid_d     = valid_q;
      err_d       = 1'b0;
      load        = 1'b0;
      load_data   = NOP_INST;

      case (state_q)
         S_IDLE: begin
            state_d = S_REQ;
            addr_d  = pc_al;
         end
         S_REQ: begin
            if (flush_i) begin
               if (ibus_gnt_i) begin
                  // Request already accepted: its response must be swallowed.
                  state_d = S_DROP;
                  cnt_d   = '0;
               end else begin
                  addr_d  = pc_al;
               end
            end else if (ibus_gnt_i) begin
               state_d = S_WAIT;
               cnt_d   = '0;
            end
         end
         S_WAIT: begin
            if (flush_i) begin
               if (ibus_rvalid_i) begin
                  state_d = S_REQ;
                  addr_d  = pc_al;
               end else begin
                  state_d = S_DROP;
                  cnt_d   = '0;
               end
            end else if (blocked) begin
               // Response (if any) stays pending on the bus until stall drops.
               if (!ibus_rvalid_i) cnt_d = cnt_inc;
            end else if (ibus_rvalid_i) begin
               load      = 1'b1;
               load_data = ibus_rdata_i;
               state_d   = S_REQ;
               addr_d    = pc_al;
            end else if (to_hit) begin
               load      = 1'b1;
               load_data = NOP_INST;
               err_d     = 1'b1;
               state_d   = S_REQ;
               addr_d    = pc_al;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_DROP: begin
            if (flush_i) begin
               if (!ibus_rvalid_i) cnt_d = cnt_inc;
            end else if (ibus_rvalid_i || to_hit) begin
               state_d = S_REQ;
               addr_d  = pc_al;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (load) begin
         inst_d      = load_data;
         inst_addr_d = addr_q;
         valid_d     = 1'b1;
      end else if (!(blocked && !flush_i)) begin
         // Consumed or flushed: fall back to the bubble instruction.
         inst_d  = NOP_INST;
         valid_d = 1'b0;
      end

      req_d = (state_d == S_REQ);
   end

   assign hold_pc_o    = !accept;
   assign ibus_req_o   = req_q;
   assign ibus_addr_o  = addr_q;
   assign inst_o       = inst_q;
   assign inst_addr_o  = inst_addr_q;
   assign inst_valid_o = valid_q;
   assign fetch_err_o  = err_q;

   // State and registered outputs, asynchronously cleared by rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         req_q       <= 1'b0;
         addr_q      <= '0;
         inst_q      <= NOP_INST;
         inst_addr_q <= '0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         req_q       <= req_d;
         addr_q      <= addr_d;
         inst_q      <= inst_d;
         inst_addr_q <= inst_addr_d;
         valid_q     <= valid_d;
         err_q       <= err_d;
      end
   end

endmodule
